// File: rtl/nibble_serial_adder.sv
// Multi-nibble adder that sequences one external 4-bit ripple adder, LSB nibble first.
// Optional subtract mode: define SERIAL_ADDER_SUB_EN to add the "sub" input.
module nibble_serial_adder #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4*NIBBLES-1:0] op_a,
    input  logic [4*NIBBLES-1:0] op_b,
    input  logic                 cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic                 sub,
`endif
    output logic [3:0]           fa_add,
    output logic [3:0]           fa_aug,
    output logic                 fa_preC,
    input  logic [3:0]           fa_sum,
    input  logic                 fa_proC,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] result,
    output logic                 cout
);

    localparam int unsigned W     = 4 * NIBBLES;
    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q;
    logic [W-1:0]     a_q, b_q, result_q;
    logic             carry_q, cout_q;
    logic             accept, last;
    logic [W-1:0]     b_load;
    logic             carry_load;

    assign accept = in_valid && (state_q == S_IDLE);
    assign last   = (idx_q == LAST_IDX);

    // Subtraction is a + ~b + 1, so only the latched augend and seed carry change.
`ifdef SERIAL_ADDER_SUB_EN
    assign b_load     = sub ? ~op_b : op_b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_load     = op_b;
    assign carry_load = cin;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_RUN;
            S_RUN:   if (last) state_d = S_DONE;
            S_DONE:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Operand capture and per-nibble accumulation of the external adder's result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q      <= '0;
            b_q      <= '0;
            carry_q  <= 1'b0;
            idx_q    <= '0;
            result_q <= '0;
            cout_q   <= 1'b0;
        end else if (accept) begin
            a_q      <= op_a;
            b_q      <= b_load;
            carry_q  <= carry_load;
            idx_q    <= '0;
            result_q <= '0;
        end else if (state_q == S_RUN) begin
            result_q[4*32'(idx_q) +: 4] <= fa_sum;
            carry_q                     <= fa_proC;
            if (last) begin
                cout_q <= fa_proC;
            end else begin
                idx_q <= idx_q + IDX_W'(1);
            end
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign cout      = cout_q;

    assign fa_add  = (state_q == S_RUN) ? a_q[4*32'(idx_q) +: 4] : 4'h0;
    assign fa_aug  = (state_q == S_RUN) ? b_q[4*32'(idx_q) +: 4] : 4'h0;
    assign fa_preC = (state_q == S_RUN) ? carry_q : 1'b0;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder (NIBBLES=4) with a behavioural 4-bit adder attached.
module tb_nibble_serial_adder;

    localparam int unsigned N = 4;
    localparam int unsigned W = 4 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready;
    logic [W-1:0] op_a, op_b;
    logic         cin;
    logic [3:0]   fa_add, fa_aug, fa_sum;
    logic         fa_preC, fa_proC;
    logic         out_valid, out_ready;
    logic [W-1:0] result;
    logic         cout;
`ifdef SERIAL_ADDER_SUB_EN
    logic         sub;
`endif

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .op_a(op_a), .op_b(op_b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .fa_add(fa_add), .fa_aug(fa_aug), .fa_preC(fa_preC),
        .fa_sum(fa_sum), .fa_proC(fa_proC),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cout(cout)
    );

    // External ripple adder model
    assign {fa_proC, fa_sum} = 5'(fa_add) + 5'(fa_aug) + 5'(fa_preC);

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    logic [W:0] exp_q[$];
    logic       pc[0:31];

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
        logic [W-1:0] r;
        logic         co;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operation, check latency and result, optionally stall in DONE.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic [W:0] expv, input int hold);
        int cyc;
        logic [W:0] got_exp;
        logic [W-1:0] r0;
        logic c0;
        cyc = 0;
        while (!in_ready && cyc < 50) begin
            tick();
            cyc++;
        end
        check("in_ready_before_op", 32'(in_ready), 32'd1);
        op_a = a; op_b = b; cin = c; in_valid = 1'b1;
        exp_q.push_back(expv);
        tick();
        in_valid = 1'b0;
        op_a = W'($urandom); op_b = W'($urandom); cin = 1'($urandom);
        check("in_ready_in_run", 32'(in_ready), 32'd0);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            pc[cyc] = fa_preC;
            tick();
            cyc++;
        end
        check("latency", 32'(cyc), 32'(N));
        got_exp = exp_q.pop_front();
        check("result", 32'(result), 32'(got_exp[W-1:0]));
        check("cout", 32'(cout), 32'(got_exp[W]));
        r0 = result; c0 = cout;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            op_a = W'($urandom); op_b = W'($urandom);
            tick();
            check("hold_out_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_result", 32'(result), 32'(r0));
            check("hold_cout", 32'(cout), 32'(c0));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("in_ready_after_done", 32'(in_ready), 32'd1);
        check("out_valid_after_done", 32'(out_valid), 32'd0);
    endtask

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W:0] m;
        logic [W-1:0] ra, rb;
        logic rc;

        vecs[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
        vecs[3] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[5] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_fa_add", 32'({fa_add, fa_aug, 3'b0, fa_preC}), 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].c, {vecs[i].co, vecs[i].r}, 0);
            if (i == 1) begin
                check("preC_nib0", 32'(pc[0]), 32'd0);
                check("preC_nib1", 32'(pc[1]), 32'd1);
                check("preC_nib2", 32'(pc[2]), 32'd1);
                check("preC_nib3", 32'(pc[3]), 32'd1);
            end
        end

        // Stall in DONE with new operands offered
        do_op(16'h1234, 16'h4321, 1'b0, {1'b0, 16'h5555}, 3);

        // Random operations against an arithmetic model
        for (int i = 0; i < 8; i++) begin
            ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
            m = (W+1)'(ra) + (W+1)'(rb) + (W+1)'(rc);
            do_op(ra, rb, rc, m, i % 2);
        end

        // Abort mid-operation with reset
        op_a = 16'hABCD; op_b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_result", 32'(result), 32'd0);
        check("abort_cout", 32'(cout), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        tick();
        rst = 1'b0;
        tick();
        do_op(16'h0F0F, 16'h00F1, 1'b0, {1'b0, 16'h1000}, 0);

`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b1;
        do_op(16'h0005, 16'h0007, 1'b1, {1'b0, 16'hFFFE}, 0);
        do_op(16'h0007, 16'h0005, 1'b0, {1'b1, 16'h0002}, 0);
        sub = 1'b0;
`endif

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
